regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter merging three write requesters into one registered RF write port.
// Define RF_ARB_R0_PROTECT_EN to treat R0 as hardwired zero (grants to R0 consumed, not written).
module regfile_wr_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req2_valid,
  input  logic [2:0]  req0_addr,
  input  logic [2:0]  req1_addr,
  input  logic [2:0]  req2_addr,
  input  logic [15:0] req0_data,
  input  logic [15:0] req1_data,
  input  logic [15:0] req2_data,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        req2_ready,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_sel,
  output logic [15:0] wr_data,
  output logic [7:0]  grant_cnt
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  ptr_nxt;
  logic [2:0]  valid;
  logic [2:0]  gnt;
  logic        any_gnt;
  logic        wr_ok;
  logic [2:0]  g_addr;
  logic [15:0] g_data;

  assign valid = {req2_valid, req1_valid, req0_valid};

  // Search starts at ptr and wraps; nothing is granted in reset or stall.
  always_comb begin
    gnt = 3'b000;
    if (reset && !hold) begin
      case (ptr)
        2'd1: begin
          if (valid[1])      gnt = 3'b010;
          else if (valid[2]) gnt = 3'b100;
          else if (valid[0]) gnt = 3'b001;
        end
        2'd2: begin
          if (valid[2])      gnt = 3'b100;
          else if (valid[0]) gnt = 3'b001;
          else if (valid[1]) gnt = 3'b010;
        end
        default: begin
          if (valid[0])      gnt = 3'b001;
          else if (valid[1]) gnt = 3'b010;
          else if (valid[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign req2_ready = gnt[2];
  assign any_gnt    = |gnt;

  always_comb begin
    g_addr  = 3'd0;
    g_data  = 16'h0000;
    ptr_nxt = ptr;
    unique case (1'b1)
      gnt[0]: begin
        g_addr  = req0_addr;
        g_data  = req0_data;
        ptr_nxt = 2'd1;
      end
      gnt[1]: begin
        g_addr  = req1_addr;
        g_data  = req1_data;
        ptr_nxt = 2'd2;
      end
      gnt[2]: begin
        g_addr  = req2_addr;
        g_data  = req2_data;
        ptr_nxt = 2'd0;
      end
      default: ;
    endcase
  end

`ifdef RF_ARB_R0_PROTECT_EN
  assign wr_ok = any_gnt && (g_addr != 3'd0);
`else
  assign wr_ok = any_gnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = wr_ok ? WRITE : IDLE;
  end

  always_comb begin
    wr_en = (state == WRITE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= 2'd0;
      grant_cnt <= 8'h00;
      wr_addr   <= 3'd0;
      wr_data   <= 16'h0000;
      wr_sel    <= 8'h00;
    end else begin
      ptr <= ptr_nxt;
      if (any_gnt) grant_cnt <= grant_cnt + 8'd1;
      if (wr_ok) begin
        wr_addr <= g_addr;
        wr_data <= g_data;
        wr_sel  <= 8'b1 << g_addr;
      end else begin
        wr_sel  <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table, directed corners, random vs reference model.
// Honours RF_ARB_R0_PROTECT_EN for the R0 expectations.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        r0v, r1v, r2v;
  logic [2:0]  r0a, r1a, r2a;
  logic [15:0] r0d, r1d, r2d;
  logic        r0y, r1y, r2y;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_sel;
  logic [15:0] wr_data;
  logic [7:0]  grant_cnt;

  regfile_wr_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(r0v), .req1_valid(r1v), .req2_valid(r2v),
    .req0_addr(r0a), .req1_addr(r1a), .req2_addr(r2a),
    .req0_data(r0d), .req1_data(r1d), .req2_data(r2d),
    .req0_ready(r0y), .req1_ready(r1y), .req2_ready(r2y),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
    .wr_data(wr_data), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

`ifdef RF_ARB_R0_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  int          m_ptr;
  int          m_cnt;
  bit          m_en;
  logic [2:0]  m_addr;
  logic [15:0] m_data;

  typedef struct {
    logic        h;
    logic [2:0]  v;
    logic [2:0]  a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic [2:0]  rdy;
    logic        en;
    logic [2:0]  wa;
    logic [7:0]  sel;
    logic [15:0] wd;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic [2:0] v,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [2:0] a2, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [15:0] d2);
    hold = h;
    {r2v, r1v, r0v} = v;
    r0a = a0; r1a = a1; r2a = a2;
    r0d = d0; r1d = d1; r2d = d2;
  endtask

  function automatic int pick(input logic [2:0] v, input int p);
    for (int i = 0; i < 3; i++) begin
      int idx;
      idx = (p + i) % 3;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_cnt = 0; m_en = 0;
    m_addr = 3'd0; m_data = 16'h0000;
  endfunction

  task automatic cyc(input string nm);
    int g;
    logic [2:0]  er;
    logic [2:0]  ga;
    logic [15:0] gd;
    logic [7:0]  es;
    #1;
    g = hold ? -1 : pick({r2v, r1v, r0v}, m_ptr);
    er = (g < 0) ? 3'b000 : 3'(1 << g);
    chk({nm, " ready"}, 32'({r2y, r1y, r0y}), 32'(er));
    ga = (g == 0) ? r0a : (g == 1) ? r1a : r2a;
    gd = (g == 0) ? r0d : (g == 1) ? r1d : r2d;
    @(posedge clk);
    m_en = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % 3;
      m_cnt = (m_cnt + 1) % 256;
      if (!(PROT && ga == 3'd0)) begin
        m_en = 1; m_addr = ga; m_data = gd;
      end
    end
    es = m_en ? 8'(1 << m_addr) : 8'h00;
    #1;
    chk({nm, " wr_en"}, 32'(wr_en), 32'(m_en));
    chk({nm, " wr_sel"}, 32'(wr_sel), 32'(es));
    chk({nm, " wr_addr"}, 32'(wr_addr), 32'(m_addr));
    chk({nm, " wr_data"}, 32'(wr_data), 32'(m_data));
    chk({nm, " cnt"}, 32'(grant_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst wr_sel", 32'(wr_sel), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    chk("rst cnt", 32'(grant_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    #2;

    tbl[0]  = '{1'b0, 3'b001, 3'd3, 3'd0, 3'd0, 16'hBEEF, 16'h0, 16'h0,
                3'b001, 1'b1, 3'd3, 8'h08, 16'hBEEF, 8'd1};
    tbl[1]  = '{1'b0, 3'b110, 3'd0, 3'd5, 3'd6, 16'h0, 16'h1111, 16'h2222,
                3'b010, 1'b1, 3'd5, 8'h20, 16'h1111, 8'd2};
    tbl[2]  = '{1'b0, 3'b110, 3'd0, 3'd5, 3'd6, 16'h0, 16'h1111, 16'h2222,
                3'b100, 1'b1, 3'd6, 8'h40, 16'h2222, 8'd3};
    tbl[3]  = '{1'b0, 3'b010, 3'd0, 3'd5, 3'd6, 16'h0, 16'h1111, 16'h2222,
                3'b010, 1'b1, 3'd5, 8'h20, 16'h1111, 8'd4};
    tbl[4]  = '{1'b1, 3'b001, 3'd7, 3'd0, 3'd0, 16'h7777, 16'h0, 16'h0,
                3'b000, 1'b0, 3'd5, 8'h00, 16'h1111, 8'd4};
    tbl[5]  = tbl[4];
    tbl[6]  = '{1'b0, 3'b001, 3'd7, 3'd0, 3'd0, 16'h7777, 16'h0, 16'h0,
                3'b001, 1'b1, 3'd7, 8'h80, 16'h7777, 8'd5};
    tbl[7]  = '{1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0,
                3'b000, 1'b0, 3'd7, 8'h00, 16'h7777, 8'd5};
    tbl[8]  = '{1'b0, 3'b010, 3'd0, 3'd4, 3'd0, 16'h0, 16'hAAAA, 16'h0,
                3'b010, 1'b1, 3'd4, 8'h10, 16'hAAAA, 8'd6};
    tbl[9]  = '{1'b0, 3'b001, 3'd4, 3'd0, 3'd0, 16'hBBBB, 16'h0, 16'h0,
                3'b001, 1'b1, 3'd4, 8'h10, 16'hBBBB, 8'd7};
    if (PROT)
      tbl[10] = '{1'b0, 3'b100, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h1234,
                  3'b100, 1'b0, 3'd4, 8'h00, 16'hBBBB, 8'd8};
    else
      tbl[10] = '{1'b0, 3'b100, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h1234,
                  3'b100, 1'b1, 3'd0, 8'h01, 16'h1234, 8'd8};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].h, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2,
            tbl[i].d0, tbl[i].d1, tbl[i].d2);
      #1;
      chk($sformatf("v%0d ready", i), 32'({r2y, r1y, r0y}), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(tbl[i].en));
      chk($sformatf("v%0d wr_sel", i), 32'(wr_sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d wr_addr", i), 32'(wr_addr), 32'(tbl[i].wa));
      chk($sformatf("v%0d wr_data", i), 32'(wr_data), 32'(tbl[i].wd));
      chk($sformatf("v%0d cnt", i), 32'(grant_cnt), 32'(tbl[i].cnt));
    end

    // all three requesters after reset: 0,1,2 then back to 0
    do_reset();
    drive(1'b0, 3'b111, 3'd1, 3'd2, 3'd3, 16'h00A0, 16'h00A1, 16'h00A2);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d ready", i), 32'({r2y, r1y, r0y}),
          32'(3'b001 << (i % 3)));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d wr_en", i), 32'(wr_en), 32'd1);
      chk($sformatf("rr%0d wr_addr", i), 32'(wr_addr), 32'((i % 3) + 1));
    end

    // reset mid-stream discards the registered write
    do_reset();
    drive(1'b0, 3'b001, 3'd2, 3'd0, 3'd0, 16'h5555, 16'h0, 16'h0);
    cyc("pre");
    drive(1'b0, 3'b011, 3'd2, 3'd6, 3'd0, 16'h5555, 16'h6666, 16'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid wr_en", 32'(wr_en), 32'd0);
    chk("mid wr_sel", 32'(wr_sel), 32'd0);
    chk("mid cnt", 32'(grant_cnt), 32'd0);
    chk("mid ready", 32'({r2y, r1y, r0y}), 32'd0);
    @(posedge clk);
    #1;
    chk("mid hold wr_en", 32'(wr_en), 32'd0);
    reset = 1'b1;
    model_reset();
    drive(1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    cyc("post idle");
    drive(1'b0, 3'b110, 3'd0, 3'd6, 3'd7, 16'h0, 16'h6666, 16'h7777);
    #1;
    chk("post prio", 32'({r2y, r1y, r0y}), 32'b010);
    cyc("post gnt");

    // grant counter wrap
    do_reset();
    drive(1'b0, 3'b001, 3'd1, 3'd0, 3'd0, 16'hC0DE, 16'h0, 16'h0);
    for (int i = 0; i < 255; i++) cyc("wrap");
    chk("cnt 255", 32'(grant_cnt), 32'd255);
    cyc("wrap last");
    chk("cnt wrap 0", 32'(grant_cnt), 32'd0);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(7) == 0), 3'($urandom_range(7)),
            3'($urandom_range(7)), 3'($urandom_range(7)),
            3'($urandom_range(7)), 16'($urandom), 16'($urandom),
            16'($urandom));
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
